sha_mem_responder: RTL and testbench
====================================

SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words stored; word addresses 0..DEPTH-1.
REQ-002 Parameter HASH_WORDS, default 8, number of hash words the tracker expects per digest.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 memory_addr  input  16  word address from SHA initiator.
REQ-006 enable_write  input  1  SHA initiator write strobe; 0 = read request.
REQ-007 memory_write_data  input  32  SHA initiator write data.
REQ-008 memory_read_data  output  32  registered read data for SHA initiator.
REQ-009 host_en, host_we  input  1 each  host access strobe and write select.
REQ-010 host_addr  input  16  host word address.
REQ-011 host_wdata  input  32  host write data (message preload).
REQ-012 host_rdata  output  32  registered host read data; host_rvalid output 1 marks it valid.
REQ-013 arm  input  1  one-cycle pulse arming the digest tracker; hash_base input 16 is sampled with it.
REQ-014 hash_done output 1, hash_word_cnt output 4, err_oob output 1, err_order output 1, host_collision output 1.

Function
REQ-015 SHA port reads every cycle enable_write=0: memory_read_data = mem[memory_addr] one cycle later (latency 1).
REQ-016 enable_write=1 writes memory_write_data to mem[memory_addr] at the edge; memory_read_data holds its previous value that cycle.
REQ-017 Host read (host_en=1, host_we=0): host_rdata = mem[host_addr] next cycle, host_rvalid=1 for exactly that cycle.
REQ-018 Read-during-write to same address on either port returns old data (read-first).
REQ-019 Both ports writing the same address in one cycle: SHA data stored, host write dropped, host_collision=1 for one cycle.
REQ-020 Address >= DEPTH: reads return 32'h0, writes dropped, err_oob set sticky until rst.
REQ-021 Tracker states IDLE, ARMED, COLLECT, DONE; IDLE->ARMED on arm, hash_base captured, hash_word_cnt=0.
REQ-022 ARMED->COLLECT on SHA write to hash_base; hash_word_cnt=1.
REQ-023 COLLECT: SHA write to hash_base+hash_word_cnt (mod 2^16) increments hash_word_cnt; on reaching HASH_WORDS go to DONE.
REQ-024 COLLECT: SHA write inside window [hash_base, hash_base+HASH_WORDS-1] (mod 2^16) at any other offset sets err_order sticky, count unchanged.
REQ-025 SHA writes outside the window ignored by tracker; host writes never affect tracker.
REQ-026 DONE: hash_done=1 held; hash_word_cnt holds HASH_WORDS; further writes ignored.
REQ-027 arm in ARMED, COLLECT or DONE: return to ARMED, recapture hash_base, cnt=0, hash_done=0; arm coinciding with a window write: arm wins, write not counted.
REQ-028 Window writes at addresses >= DEPTH still count toward tracking (data dropped, err_oob set).
REQ-029 Window wrap: hash_base=16'hFFFC covers FFFC..FFFF,0000..0003.

Reset
REQ-030 rst=1 at an edge: tracker IDLE, hash_word_cnt=0, hash_done=0, err_oob=0, err_order=0, host_collision=0, host_rvalid=0, memory_read_data=0, host_rdata=0.
REQ-031 Memory array contents are not cleared by rst; reset mid-COLLECT abandons the digest.

Structure
REQ-032 Package sha_mem_pkg holds the tracker state enum, DEPTH and HASH_WORDS defaults.
REQ-033 Tracker FSM is sub-module sha_hash_tracker; storage and port logic stay in sha_mem_responder.

Verification
REQ-034 Host write 32'h61626380 to addr 0, host read addr 0 -> host_rdata=32'h61626380 with host_rvalid one cycle later.
REQ-035 SHA read addr 0 after preload -> memory_read_data=32'h61626380 exactly one cycle after address presented.
REQ-036 arm with hash_base=16'h0010, SHA writes 0x10..0x17 in order -> hash_done=1 after 8th write, hash_word_cnt=8.
REQ-037 Armed at 0x0010, writes 0x10,0x12 -> err_order=1, hash_word_cnt=1, hash_done=0.
REQ-038 Same-cycle SHA write 32'hAAAA0000 and host write 32'h5555FFFF to addr 5 -> mem[5]=32'hAAAA0000, host_collision pulse.
REQ-039 SHA write to addr 300 (DEPTH=256) -> err_oob=1, read addr 300 returns 0; rst mid-COLLECT -> IDLE, hash_done=0.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// Shared constants and tracker state encoding for the SHA message/digest memory responder.
package sha_mem_pkg;

    localparam int DEPTH_DEF      = 256;
    localparam int HASH_WORDS_DEF = 8;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 32;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        TRK_IDLE    = 2'd0,
        TRK_ARMED   = 2'd1,
        TRK_COLLECT = 2'd2,
        TRK_DONE    = 2'd3
    } trk_state_e;

endpackage

// File: rtl/sha_hash_tracker.sv
// Watches SHA-side writes and confirms the digest words land in order inside the armed window.
import sha_mem_pkg::*;

module sha_hash_tracker #(
    parameter int HASH_WORDS = HASH_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic [ADDR_W-1:0] hash_base_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              hash_done_o,
    output logic [CNT_W-1:0]  hash_word_cnt_o,
    output logic              err_order_o
);

    trk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] offset;
    logic              in_win;

    // Offset arithmetic is mod 2^16 so a window near the top of the address space wraps to 0.
    assign offset = wr_addr_i - base_q;
    assign in_win = 32'(offset) < 32'(HASH_WORDS);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (arm_i) begin
            state_d = TRK_ARMED;
            base_d  = hash_base_i;
            cnt_d   = '0;
        end else if (wr_en_i) begin
            case (state_q)
                TRK_ARMED: begin
                    if (offset == '0) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (HASH_WORDS == 1) ? TRK_DONE : TRK_COLLECT;
                    end
                end
                TRK_COLLECT: begin
                    if (offset == {{(ADDR_W-CNT_W){1'b0}}, cnt_q}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (32'(cnt_q) + 32'd1 == 32'(HASH_WORDS))
                            state_d = TRK_DONE;
                    end else if (in_win) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRK_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign hash_done_o     = (state_q == TRK_DONE);
    assign hash_word_cnt_o = cnt_q;
    assign err_order_o     = err_q;

endmodule

// File: rtl/sha_mem_responder.sv
// Dual-port word memory serving a SHA initiator and a host preload port, plus digest tracking.
import sha_mem_pkg::*;

module sha_mem_responder #(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int HASH_WORDS = HASH_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memory_addr,
    input  logic              enable_write,
    input  logic [DATA_W-1:0] memory_write_data,
    output logic [DATA_W-1:0] memory_read_data,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              arm,
    input  logic [ADDR_W-1:0] hash_base,
    output logic              hash_done,
    output logic [CNT_W-1:0]  hash_word_cnt,
    output logic              err_oob,
    output logic              err_order,
    output logic              host_collision
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              err_oob_q, err_oob_d;
    logic              collision_q, collision_d;

    logic sha_in, host_in, sha_wr, host_rd, host_wr_req, host_wr, collide;

    assign sha_in      = 32'(memory_addr) < 32'(DEPTH);
    assign host_in     = 32'(host_addr) < 32'(DEPTH);
    assign sha_wr      = enable_write && sha_in;
    assign host_rd     = host_en && !host_we;
    assign host_wr_req = host_en && host_we;
    // SHA side owns the word when both ports write it in the same cycle.
    assign collide     = enable_write && host_wr_req && (host_addr == memory_addr);
    assign host_wr     = host_wr_req && host_in && !collide;

    always_comb begin
        mem_rdata_d   = mem_rdata_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = host_rd;
        collision_d   = collide;
        err_oob_d     = err_oob_q || !sha_in || (host_en && !host_in);
        if (!enable_write)
            mem_rdata_d = sha_in ? mem[memory_addr[AW-1:0]] : '0;
        if (host_rd)
            host_rdata_d = host_in ? mem[host_addr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            err_oob_q     <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            mem_rdata_q   <= mem_rdata_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            err_oob_q     <= err_oob_d;
            collision_q   <= collision_d;
        end
    end

    // Storage is deliberately left out of reset so a preloaded message survives it.
    always_ff @(posedge clk) begin
        if (sha_wr)
            mem[memory_addr[AW-1:0]] <= memory_write_data;
        if (host_wr)
            mem[host_addr[AW-1:0]] <= host_wdata;
    end

    sha_hash_tracker #(
        .HASH_WORDS (HASH_WORDS)
    ) u_tracker (
        .clk             (clk),
        .rst             (rst),
        .arm_i           (arm),
        .hash_base_i     (hash_base),
        .wr_en_i         (enable_write),
        .wr_addr_i       (memory_addr),
        .hash_done_o     (hash_done),
        .hash_word_cnt_o (hash_word_cnt),
        .err_order_o     (err_order)
    );

    assign memory_read_data = mem_rdata_q;
    assign host_rdata       = host_rdata_q;
    assign host_rvalid      = host_rvalid_q;
    assign err_oob          = err_oob_q;
    assign host_collision   = collision_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed checks of the SHA memory responder: ports, collisions, out-of-range and digest tracking.
module tb_sha_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memory_addr;
    logic        enable_write;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        host_en, host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        arm;
    logic [15:0] hash_base;
    logic        hash_done;
    logic [3:0]  hash_word_cnt;
    logic        err_oob, err_order, host_collision;

    int n_cmp = 0;
    int n_err = 0;

    sha_mem_responder #(.DEPTH(256), .HASH_WORDS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .memory_addr       (memory_addr),
        .enable_write      (enable_write),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .host_en           (host_en),
        .host_we           (host_we),
        .host_addr         (host_addr),
        .host_wdata        (host_wdata),
        .host_rdata        (host_rdata),
        .host_rvalid       (host_rvalid),
        .arm               (arm),
        .hash_base         (hash_base),
        .hash_done         (hash_done),
        .hash_word_cnt     (hash_word_cnt),
        .err_oob           (err_oob),
        .err_order         (err_order),
        .host_collision    (host_collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    initial begin
        rst = 1'b1; memory_addr = '0; enable_write = 1'b0; memory_write_data = '0;
        host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        arm = 1'b0; hash_base = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdata", memory_read_data, 32'h0);
        chk("rst_hrdata", host_rdata, 32'h0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_done", 32'(hash_done), 32'd0);
        chk("rst_cnt", 32'(hash_word_cnt), 32'd0);
        chk("rst_flags", {29'b0, err_oob, err_order, host_collision}, 32'd0);

        // Host preload and read-back
        host_en = 1'b1; host_we = 1'b1; host_addr = 16'd0; host_wdata = 32'h61626380; tick();
        host_addr = 16'd1; host_wdata = 32'h11111111; tick();
        host_we = 1'b0; host_addr = 16'd0; tick();
        chk("host_rd", host_rdata, 32'h61626380);
        chk("host_rvalid1", 32'(host_rvalid), 32'd1);
        host_en = 1'b0; tick();
        chk("host_rvalid0", 32'(host_rvalid), 32'd0);

        // SHA reads, latency one
        memory_addr = 16'd1; tick();
        chk("sha_rd1", memory_read_data, 32'h11111111);
        memory_addr = 16'd0; tick();
        chk("sha_rd0", memory_read_data, 32'h61626380);

        // SHA write holds read data; read-first on the host port
        enable_write = 1'b1; memory_addr = 16'd1; memory_write_data = 32'h22222222; tick();
        chk("wr_hold", memory_read_data, 32'h61626380);
        enable_write = 1'b0; tick();
        chk("sha_rd_new", memory_read_data, 32'h22222222);
        enable_write = 1'b1; memory_write_data = 32'h33333333;
        host_en = 1'b1; host_we = 1'b0; host_addr = 16'd1; tick();
        chk("rdw_old", host_rdata, 32'h22222222);
        host_en = 1'b0; enable_write = 1'b0; tick();
        chk("rdw_new", memory_read_data, 32'h33333333);

        // Same-address write collision
        enable_write = 1'b1; memory_addr = 16'd5; memory_write_data = 32'hAAAA0000;
        host_en = 1'b1; host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'h5555FFFF; tick();
        chk("coll_pulse", 32'(host_collision), 32'd1);
        enable_write = 1'b0; host_en = 1'b0; host_we = 1'b0; tick();
        chk("coll_clear", 32'(host_collision), 32'd0);
        chk("coll_data", memory_read_data, 32'hAAAA0000);
        chk("no_oob_yet", 32'(err_oob), 32'd0);

        // In-order digest at 0x10
        arm = 1'b1; hash_base = 16'h0010; memory_addr = 16'd0; tick();
        arm = 1'b0;
        chk("armed_cnt", 32'(hash_word_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            enable_write = 1'b1; memory_addr = 16'h0010 + 16'(i); memory_write_data = 32'(i); tick();
            chk("seq_cnt", 32'(hash_word_cnt), 32'(i + 1));
            chk("seq_done", 32'(hash_done), (i == 7) ? 32'd1 : 32'd0);
        end
        memory_addr = 16'h0010; tick();
        chk("done_hold_cnt", 32'(hash_word_cnt), 32'd8);
        chk("done_hold", 32'(hash_done), 32'd1);
        chk("done_no_order", 32'(err_order), 32'd0);

        // Out-of-order write
        enable_write = 1'b0; arm = 1'b1; tick();
        arm = 1'b0;
        chk("rearm_done", 32'(hash_done), 32'd0);
        enable_write = 1'b1; memory_addr = 16'h0010; tick();
        memory_addr = 16'h0012; tick();
        chk("ooo_err", 32'(err_order), 32'd1);
        chk("ooo_cnt", 32'(hash_word_cnt), 32'd1);
        chk("ooo_done", 32'(hash_done), 32'd0);

        // Arm coinciding with a window write: write not counted
        arm = 1'b1; memory_addr = 16'h0010; tick();
        arm = 1'b0;
        chk("arm_wins", 32'(hash_word_cnt), 32'd0);
        tick();
        chk("arm_then_first", 32'(hash_word_cnt), 32'd1);

        // Out-of-range write and read
        memory_addr = 16'd300; memory_write_data = 32'hDEADBEEF; tick();
        chk("oob_flag", 32'(err_oob), 32'd1);
        enable_write = 1'b0; tick();
        chk("oob_rd", memory_read_data, 32'h0);
        tick();
        chk("oob_sticky", 32'(err_oob), 32'd1);

        // Reset mid-collect; memory survives
        memory_addr = 16'd0; arm = 1'b1; hash_base = 16'h0020; tick();
        arm = 1'b0; enable_write = 1'b1; memory_addr = 16'h0020; tick();
        memory_addr = 16'h0021; tick();
        chk("pre_rst_cnt", 32'(hash_word_cnt), 32'd2);
        enable_write = 1'b0; memory_addr = 16'd5; rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(hash_word_cnt), 32'd0);
        chk("mid_rst_flags", {28'b0, hash_done, err_oob, err_order, host_collision}, 32'd0);
        tick();
        chk("mem_kept", memory_read_data, 32'hAAAA0000);
        memory_addr = 16'h0022; enable_write = 1'b1; tick();
        chk("idle_ignores", 32'(hash_word_cnt), 32'd0);

        // Window wrapping through 0xFFFF
        enable_write = 1'b0; arm = 1'b1; hash_base = 16'hFFFC; tick();
        arm = 1'b0; enable_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            memory_addr = 16'hFFFC + 16'(i); tick();
        end
        chk("wrap_cnt", 32'(hash_word_cnt), 32'd8);
        chk("wrap_done", 32'(hash_done), 32'd1);
        chk("wrap_order", 32'(err_order), 32'd0);
        enable_write = 1'b0; memory_addr = 16'd0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
